// File: rtl/turn_request_ctrl_if.sv
// Button inputs and light-request outputs of the turn/hazard front end.
// The bench drives through master; the controller uses slave.
interface turn_request_ctrl_if;
  logic       left_btn;
  logic       right_btn;
  logic       hazard_btn;
  logic       L;
  logic       R;
  logic       E;
  logic [1:0] state;

  modport master (
    output left_btn, right_btn, hazard_btn,
    input  L, R, E, state
  );

  modport slave (
    input  left_btn, right_btn, hazard_btn,
    output L, R, E, state
  );
endinterface

// File: rtl/turn_request_ctrl.sv
// Tail-light front end: synchronise and debounce three buttons, then sequence
// the left/right/hazard request with an auto-cancel timer on turn requests.
//
//   state  | meaning
//   IDLE   | no request, L R E = 0 0 0
//   LEFT   | left turn request, L R E = 1 0 0, timer running
//   RIGHT  | right turn request, L R E = 0 1 0, timer running
//   HAZARD | hazard request, L R E = 1 1 1, returns to saved state on next hazard press
module turn_request_ctrl #(
  parameter int DB_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset,
  turn_request_ctrl_if.slave bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } state_t;

  // bit 0 = left, bit 1 = right, bit 2 = hazard
  logic [2:0]         raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         level;
  logic [2:0]         press;
  logic [2:0][CW-1:0] db_cnt;

  assign raw = {bus.hazard_btn, bus.right_btn, bus.left_btn};

  // Press pulse is issued on the same edge the debounced level rises,
  // so the FSM reacts one edge after the flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          press[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t        state_q;
  state_t        state_d;
  state_t        saved_q;
  state_t        saved_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          l_q;
  logic          r_q;
  logic          e_q;
  logic          l_d;
  logic          r_d;
  logic          e_d;
  logic          lp;
  logic          rp;
  logic          hp;
  logic          expired;

  // Left and right together cancel each other; hazard always wins.
  assign hp      = press[2];
  assign lp      = press[0] & ~press[1];
  assign rp      = press[1] & ~press[0];
  assign expired = (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (hp) begin
          state_d = HAZARD;
          saved_d = IDLE;
        end else if (lp) begin
          state_d = LEFT;
        end else if (rp) begin
          state_d = RIGHT;
        end
      end
      LEFT: begin
        if (hp) begin
          state_d = HAZARD;
          saved_d = LEFT;
        end else if (lp) begin
          state_d = IDLE;
        end else if (rp) begin
          state_d = RIGHT;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      RIGHT: begin
        if (hp) begin
          state_d = HAZARD;
          saved_d = RIGHT;
        end else if (rp) begin
          state_d = IDLE;
        end else if (lp) begin
          state_d = LEFT;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      HAZARD: begin
        if (hp) begin
          state_d = saved_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any entry into a turn state (including left<->right switch) restarts the timer.
    if (state_d == LEFT || state_d == RIGHT) begin
      timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    end

    l_d = (state_d == LEFT)  || (state_d == HAZARD);
    r_d = (state_d == RIGHT) || (state_d == HAZARD);
    e_d = (state_d == HAZARD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      saved_q <= IDLE;
      timer_q <= '0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      timer_q <= timer_d;
      l_q     <= l_d;
      r_q     <= r_d;
      e_q     <= e_d;
    end
  end

  assign bus.L     = l_q;
  assign bus.R     = r_q;
  assign bus.E     = e_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_turn_request_ctrl.sv
// Directed bench for turn_request_ctrl with DB_CYCLES=4, TIMEOUT_CYCLES=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_turn_request_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  turn_request_ctrl_if bus();

  turn_request_ctrl #(
    .DB_CYCLES      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] lre, input logic [1:0] st);
    check({tag, ".lre"},   {1'b0, bus.L, bus.R, bus.E}, {1'b0, lre});
    check({tag, ".state"}, {2'b00, bus.state},          {2'b00, st});
  endtask

  // Each call advances to the falling edge after n more rising edges.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    bus.left_btn   = 1'b0;
    bus.right_btn  = 1'b0;
    bus.hazard_btn = 1'b0;
    cyc(2);
    expect_out("reset", 3'b000, 2'b00);
    reset = 1'b0;
    cyc(2);
    expect_out("post_reset", 3'b000, 2'b00);

    // 1: left held 10 cycles, LEFT at edge 7, auto-cancel 16 cycles later
    bus.left_btn = 1'b1;
    cyc(6);
    expect_out("t1_edge6", 3'b000, 2'b00);
    cyc(1);
    expect_out("t1_edge7", 3'b100, 2'b01);
    cyc(3);
    bus.left_btn = 1'b0;
    cyc(12);
    expect_out("t1_edge22", 3'b100, 2'b01);
    cyc(1);
    expect_out("t1_edge23", 3'b000, 2'b00);
    cyc(10);

    // 2: bouncing left button never produces a press
    for (int i = 0; i < 3; i++) begin
      bus.left_btn = 1'b1;
      cyc(2);
      bus.left_btn = 1'b0;
      cyc(2);
      expect_out("t2_bounce", 3'b000, 2'b00);
    end
    cyc(12);
    expect_out("t2_settled", 3'b000, 2'b00);

    // 3: right press while LEFT switches same edge, full 16 cycles of RIGHT
    bus.left_btn = 1'b1;
    cyc(7);
    expect_out("t3_left", 3'b100, 2'b01);
    cyc(1);
    bus.left_btn = 1'b0;
    cyc(2);
    bus.right_btn = 1'b1;
    cyc(6);
    expect_out("t3_edge16", 3'b100, 2'b01);
    cyc(1);
    expect_out("t3_edge17", 3'b010, 2'b10);
    cyc(4);
    bus.right_btn = 1'b0;
    cyc(11);
    expect_out("t3_edge32", 3'b010, 2'b10);
    cyc(1);
    expect_out("t3_edge33", 3'b000, 2'b00);
    cyc(10);

    // 4: hazard entered at timer 5 of LEFT, held 40 cycles, back to LEFT with fresh timer
    bus.left_btn = 1'b1;
    cyc(6);
    bus.hazard_btn = 1'b1;
    cyc(1);
    expect_out("t4_left", 3'b100, 2'b01);
    cyc(1);
    bus.left_btn = 1'b0;
    cyc(4);
    expect_out("t4_edge12", 3'b100, 2'b01);
    cyc(1);
    expect_out("t4_hazard", 3'b111, 2'b11);
    cyc(1);
    bus.hazard_btn = 1'b0;
    cyc(32);
    expect_out("t4_edge46", 3'b111, 2'b11);
    bus.hazard_btn = 1'b1;
    cyc(6);
    expect_out("t4_edge52", 3'b111, 2'b11);
    cyc(1);
    expect_out("t4_back_left", 3'b100, 2'b01);
    cyc(2);
    bus.hazard_btn = 1'b0;
    cyc(13);
    expect_out("t4_edge68", 3'b100, 2'b01);
    cyc(1);
    expect_out("t4_timeout", 3'b000, 2'b00);
    cyc(10);

    // 5: left+right together ignored; hazard+left -> HAZARD returning to IDLE
    bus.left_btn  = 1'b1;
    bus.right_btn = 1'b1;
    cyc(7);
    expect_out("t5_lr_edge7", 3'b000, 2'b00);
    cyc(1);
    bus.left_btn  = 1'b0;
    bus.right_btn = 1'b0;
    cyc(6);
    expect_out("t5_lr_after", 3'b000, 2'b00);
    cyc(4);
    bus.left_btn   = 1'b1;
    bus.hazard_btn = 1'b1;
    cyc(7);
    expect_out("t5_hl_edge7", 3'b111, 2'b11);
    cyc(1);
    bus.left_btn   = 1'b0;
    bus.hazard_btn = 1'b0;
    cyc(8);
    bus.hazard_btn = 1'b1;
    cyc(6);
    expect_out("t5_hz_hold", 3'b111, 2'b11);
    cyc(1);
    expect_out("t5_saved_idle", 3'b000, 2'b00);
    cyc(2);
    bus.hazard_btn = 1'b0;
    cyc(10);

    // 6: async reset mid-RIGHT clears outputs immediately; next press fully debounced
    bus.right_btn = 1'b1;
    cyc(7);
    expect_out("t6_right", 3'b010, 2'b10);
    cyc(1);
    bus.right_btn = 1'b0;
    cyc(3);
    #2 reset = 1'b1;
    #1 expect_out("t6_async_reset", 3'b000, 2'b00);
    #1 reset = 1'b0;
    @(negedge clk);
    bus.right_btn = 1'b1;
    cyc(6);
    expect_out("t6_edge6", 3'b000, 2'b00);
    cyc(1);
    expect_out("t6_edge7", 3'b010, 2'b10);
    bus.right_btn = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
